// File: rtl/key_debounce.sv
// Per-channel two-flop synchroniser, stable-window debouncer and press/release pulse generator.
// Optional long-press pulse: compile with KEY_DEBOUNCE_LONG_PRESS_EN defined.
module key_debounce #(
    parameter int KEY_W        = 4,
    parameter int DEBOUNCE_CYC = 240000,
    parameter int PRESS_LEVEL  = 1,
    parameter int LONG_CYC     = 12000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_raw,
    output logic [KEY_W-1:0] key_state,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic [KEY_W-1:0] key_long
);

    localparam int   CNT_W     = $clog2(DEBOUNCE_CYC + 1);
    localparam logic PRESS_BIT = (PRESS_LEVEL != 0);

    if (DEBOUNCE_CYC < 2 || LONG_CYC < 2) begin : g_bad_param
        $error("key_debounce: DEBOUNCE_CYC and LONG_CYC must be at least 2");
    end

    logic [KEY_W-1:0] sync1;
    logic [KEY_W-1:0] sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= {KEY_W{~PRESS_BIT}};
            sync2 <= {KEY_W{~PRESS_BIT}};
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < KEY_W; i++) begin : g_ch
        logic             n;
        logic [CNT_W-1:0] cnt;
        logic             state_q;
        logic             press_q;
        logic             release_q;

        assign n = (sync2[i] == PRESS_BIT);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt       <= '0;
                state_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                if (n == state_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    state_q   <= n;
                    cnt       <= '0;
                    press_q   <= n;
                    release_q <= ~n;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign key_state[i]   = state_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        localparam int LONG_W = $clog2(LONG_CYC + 1);

        logic [LONG_W-1:0] hold_cnt;
        logic              long_q;

        // The press pulse trails key_state by one clock, so clearing on it and
        // counting from the next clock lands key_long exactly LONG_CYC after key_press.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hold_cnt <= '0;
                long_q   <= 1'b0;
            end else if (!state_q || press_q) begin
                hold_cnt <= '0;
                long_q   <= 1'b0;
            end else if (hold_cnt != LONG_W'(LONG_CYC - 1)) begin
                hold_cnt <= hold_cnt + 1'b1;
                long_q   <= (hold_cnt == LONG_W'(LONG_CYC - 2));
            end else begin
                long_q   <= 1'b0;
            end
        end

        assign key_long[i] = long_q;
`else
        assign key_long[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_debounce.sv
// Randomised and directed bench for key_debounce against a sample-window reference model.
`timescale 1ns/1ps
module tb_key_debounce;

    localparam int KW   = 4;
    localparam int DEB  = 8;
    localparam int LONG = 32;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [KW-1:0] key_raw;
    logic [KW-1:0] key_state;
    logic [KW-1:0] key_press;
    logic [KW-1:0] key_release;
    logic [KW-1:0] key_long;

    key_debounce #(
        .KEY_W       (KW),
        .DEBOUNCE_CYC(DEB),
        .PRESS_LEVEL (1),
        .LONG_CYC    (LONG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_raw    (key_raw),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #41.667 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: a level is accepted once the last DEB delayed samples
    // all differ from the accepted level; long press is a pure time offset.
    logic [KW-1:0]  m_d1, m_d2, m_state, m_press, m_rel, m_long;
    logic [DEB-1:0] hist   [KW];
    int             hvalid [KW];
    longint         press_cyc [KW];
    longint         cyc = 0;

    task automatic model_step(input logic rst, input logic [KW-1:0] raw);
        logic [KW-1:0] pre_state;
        cyc++;
        pre_state = m_state;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        if (!rst) begin
            m_d1    = '0;
            m_d2    = '0;
            m_state = '0;
            for (int c = 0; c < KW; c++) hvalid[c] = 0;
        end else begin
            for (int c = 0; c < KW; c++) begin
                hist[c] = {hist[c][DEB-2:0], m_d2[c]};
                if (hvalid[c] < DEB) hvalid[c]++;
                if (LONG_EN && pre_state[c] && (cyc - press_cyc[c] == LONG))
                    m_long[c] = 1'b1;
                if (hvalid[c] == DEB && hist[c] == (pre_state[c] ? {DEB{1'b0}} : {DEB{1'b1}})) begin
                    m_state[c] = ~pre_state[c];
                    m_press[c] = m_state[c];
                    m_rel[c]   = ~m_state[c];
                    if (m_state[c]) press_cyc[c] = cyc;
                    hvalid[c]  = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = raw;
        end
    endtask

    logic [KW-1:0] seen_any;

    task automatic tick();
        @(posedge clk);
        model_step(rst_n, key_raw);
        #1;
        check("state",   32'(key_state),   32'(m_state));
        check("press",   32'(key_press),   32'(m_press));
        check("release", 32'(key_release), 32'(m_rel));
        check("long",    32'(key_long),    32'(m_long));
        seen_any = seen_any | key_press | key_release | key_long;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    int nlong;
    int rem [KW];

    initial begin
        for (int c = 0; c < KW; c++) begin
            press_cyc[c] = -1000;
            hist[c]      = '0;
            hvalid[c]    = 0;
            rem[c]       = 0;
        end
        m_d1 = '0; m_d2 = '0; m_state = '0;
        m_press = '0; m_rel = '0; m_long = '0;
        seen_any = '0;

        // Reset with all keys held, then release reset with keys still held
        rst_n   = 1'b0;
        key_raw = 4'b1111;
        ticks(5);
        check("rst_state", 32'(key_state), 32'h0);
        rst_n = 1'b1;
        seen_any = '0;
        ticks(9);
        check("rst_exit_state", 32'(key_state), 32'h0);
        check("rst_exit_pulse", 32'(seen_any), 32'h0);
        tick();
        check("rst_held_state", 32'(key_state), 32'hF);
        check("rst_held_press", 32'(key_press), 32'hF);
        tick();
        check("rst_held_press_end", 32'(key_press), 32'h0);

        key_raw = 4'b0000;
        ticks(12);

        // Clean press and release on channel 0
        key_raw[0] = 1'b1;
        ticks(9);
        check("ch0_pre", 32'(key_state[0]), 32'h0);
        tick();
        check("ch0_state", 32'(key_state[0]), 32'h1);
        check("ch0_press", 32'(key_press[0]), 32'h1);
        ticks(4);
        key_raw[0] = 1'b0;
        ticks(9);
        check("ch0_pre_rel", 32'(key_release[0]), 32'h0);
        tick();
        check("ch0_release", 32'(key_release[0]), 32'h1);
        check("ch0_state_rel", 32'(key_state[0]), 32'h0);
        ticks(4);

        // Bounces of DEB-1 clocks never get through
        seen_any = '0;
        for (int r = 0; r < 4; r++) begin
            key_raw[1] = 1'b1;
            ticks(DEB - 1);
            key_raw[1] = 1'b0;
            ticks(2);
        end
        ticks(12);
        check("bounce_state", 32'(key_state), 32'h0);
        check("bounce_pulse", 32'(seen_any), 32'h0);

        // Simultaneous press on two channels
        key_raw = 4'b0101;
        ticks(10);
        check("multi_press", 32'(key_press), 32'h5);
        check("multi_state", 32'(key_state), 32'h5);
        tick();
        check("multi_press_end", 32'(key_press), 32'h0);
        key_raw = 4'b0000;
        ticks(12);

        // Long hold on channel 2
        nlong = 0;
        key_raw[2] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (key_long[2]) nlong++;
        end
        check("long_count", 32'(nlong), LONG_EN ? 32'd1 : 32'd0);
        key_raw[2] = 1'b0;
        ticks(12);

        // Short hold gives no long press
        nlong = 0;
        key_raw[2] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (key_long[2]) nlong++;
        end
        key_raw[2] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (key_long[2]) nlong++;
        end
        check("short_hold_long", 32'(nlong), 32'h0);

        // Reset mid-count discards the partial window
        key_raw[3] = 1'b1;
        ticks(7);
        rst_n = 1'b0;
        tick();
        check("midrst_pulse", 32'(key_press), 32'h0);
        rst_n = 1'b1;
        ticks(9);
        check("midrst_pre", 32'(key_state[3]), 32'h0);
        tick();
        check("midrst_state", 32'(key_state[3]), 32'h1);
        check("midrst_press", 32'(key_press[3]), 32'h1);
        key_raw = 4'b0000;
        ticks(12);

        // Random bursts per channel, occasional one-clock reset
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < KW; c++) begin
                if (rem[c] == 0) begin
                    key_raw[c] = 1'($urandom_range(0, 1));
                    rem[c]     = (($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                                             : int'($urandom_range(1, 12)));
                end
                rem[c]--;
            end
            rst_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1;
        key_raw = 4'b0000;
        ticks(12);
        check("final_state", 32'(key_state), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Receiving end of the push-button and switch input path: conditions raw `key_input`/`sw_input` levels from board pins or the bench stimulus into clean, debounced levels and single-cycle event pulses.
- Sits directly behind the top-level input pins.
- Feeds the mode/rate control logic that drives `led`, `seg1` and `seg2`.
- One instance per input group: keys and switches are instantiated separately with their own `KEY_W`.

Parameters:
- KEY_W, 4, number of independent input channels.
- DEBOUNCE_CYC, 240000, consecutive stable clocks required to accept a new level (20 ms at 12 MHz); must be ≥2.
- PRESS_LEVEL, 1, raw pin level meaning "pressed"/"on" (1 = active-high, matching bench stimulus where 4'b1111 is all pressed).
- LONG_CYC, 12000000, clocks a key must remain pressed after acceptance before the long-press pulse (1 s at 12 MHz); only used with the optional feature.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst_n  input  1  reset; synchronous, active-low.
- key_raw  input  KEY_W  asynchronous raw pin levels.
- key_state  output  KEY_W  debounced level per channel; 1 = pressed, independent of PRESS_LEVEL.
- key_press  output  KEY_W  one-clock pulse when key_state rises.
- key_release  output  KEY_W  one-clock pulse when key_state falls.
- key_long  output  KEY_W  one-clock long-press pulse; tied 0 when feature compiled out.

Behaviour:
- Reset, sampled on rising clk with rst_n=0:
  - key_state, key_press, key_release, key_long = 0.
  - Synchronizer flops loaded with the released level (~PRESS_LEVEL).
  - All counters = 0.
  - Reset asserted mid-count discards any partial count; no pulse is emitted on reset exit, even if a key is held.
- Per channel, fully independent, no shared state:
  - Two-flop synchronizer on key_raw, then normalised to n = (sync2 == PRESS_LEVEL).
  - Counter cnt, width $clog2(DEBOUNCE_CYC+1).
  - If n == key_state: cnt <= 0.
  - If n != key_state and cnt < DEBOUNCE_CYC-1: cnt <= cnt+1.
  - If n != key_state and cnt == DEBOUNCE_CYC-1: key_state <= n, cnt <= 0, and key_press (n=1) or key_release (n=0) asserted for exactly that one clock.
- Latency: a clean level change on key_raw appears on key_state exactly DEBOUNCE_CYC+2 rising edges later; the press/release pulse is coincident with the key_state change.
- Glitch rejection:
  - Any return to the accepted level before DEBOUNCE_CYC consecutive differing clocks resets cnt to 0.
  - A bounce of DEBOUNCE_CYC-1 clocks or shorter never changes key_state.
- No wrap-around: cnt saturates at the accept condition and clears.
- Simultaneous events: several channels may pulse in the same clock. key_press and key_release never assert together on one channel.
- All outputs registered; no combinational path from key_raw to any output.

Optional Feature:
- Macro KEY_DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - Per-channel hold counter, width $clog2(LONG_CYC+1), cleared while key_state=0 and on key_press.
  - Counter increments each clock while key_state=1; on reaching LONG_CYC-1, key_long pulses one clock and the counter holds.
  - Exactly one key_long per press, LONG_CYC clocks after key_press.
  - Release before LONG_CYC produces no key_long.
  - Reset clears the counter.
- Undefined: no hold counters synthesised; key_long driven constant 0. Port list unchanged.

Test Plan (bench overrides DEBOUNCE_CYC=8, LONG_CYC=32, PRESS_LEVEL=1, 12 MHz clk):
- Hold rst_n=0 with key_raw=4'b1111 for 5 clocks, then release reset with keys still held:
  - All outputs 0 during reset and on exit, with no pulse at release.
  - key_state=4'b1111 exactly 10 edges after reset release, with key_press=4'b1111 for one clock.
- key_raw[0] 0→1 clean:
  - key_state[0] rises exactly 10 edges after change, with key_press[0] for one clock.
  - Release gives key_release[0] pulse 10 edges after key_raw[0] falls.
- key_raw[1] bursts 1 for 7 clocks, 0 for 2, repeated 4×:
  - key_state[1] stays 0; no pulses on any output.
- key_raw=4'b0101 applied in one clock:
  - key_press=4'b0101 in the same single clock; channels 1 and 3 remain 0.
- Macro defined, key_raw[2] held 60 clocks:
  - key_long[2] pulses once, 32 clocks after key_press[2].
  - A 20-clock hold gives no key_long.
  - Macro undefined: key_long stays 4'b0000 throughout.
- Assert rst_n=0 for 1 clock when cnt=5 during a press:
  - cnt restarts; key_state rises only after a fresh 8-clock stable window, with no pulse on the reset clock.
